// File: rtl/dac_scan_sequencer.sv
// Register-programmed level scan for the MCP4921 SPI DAC master: code, frame request, dwell gate.
// Optional down sweep after the upper end is enabled by defining SCAN_BIDIR_EN.
module dac_scan_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CODE_WIDTH  = 12,
  parameter int unsigned DWELL_WIDTH = 16,
  parameter int unsigned SPI_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  nres,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CODE_WIDTH-1:0] dac_code,
  output logic                  dac_start_step,
  input  logic                  dac_done,
  output logic                  count_gate,
  output logic                  busy,
  output logic                  scan_done
);

  localparam int unsigned HiW = CODE_WIDTH - 8;
  localparam int unsigned ToW = $clog2(SPI_TIMEOUT + 1);
  localparam logic [ToW-1:0] ToMax = ToW'(SPI_TIMEOUT - 1);

  localparam logic [DATA_WIDTH-1:0] AddrCtrl    = DATA_WIDTH'('h30);
  localparam logic [DATA_WIDTH-1:0] AddrStartLo = DATA_WIDTH'('h31);
  localparam logic [DATA_WIDTH-1:0] AddrStartHi = DATA_WIDTH'('h32);
  localparam logic [DATA_WIDTH-1:0] AddrStopLo  = DATA_WIDTH'('h33);
  localparam logic [DATA_WIDTH-1:0] AddrStopHi  = DATA_WIDTH'('h34);
  localparam logic [DATA_WIDTH-1:0] AddrStep    = DATA_WIDTH'('h35);
  localparam logic [DATA_WIDTH-1:0] AddrDwellLo = DATA_WIDTH'('h36);
  localparam logic [DATA_WIDTH-1:0] AddrDwellHi = DATA_WIDTH'('h37);
  localparam logic [DATA_WIDTH-1:0] AddrStatus  = DATA_WIDTH'('h38);
  localparam logic [DATA_WIDTH-1:0] AddrPoints  = DATA_WIDTH'('h39);

  typedef enum logic [2:0] {StIdle, StLoad, StWaitDac, StDwell, StNext, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CODE_WIDTH-1:0]  start_q, stop_q, sh_start_q, sh_stop_q;
  logic [7:0]             step_q, sh_step_q;
  logic [DWELL_WIDTH-1:0] dwell_q, sh_dwell_q;
  logic                   cont_q;
  logic                   bidir_en;
  logic [CODE_WIDTH-1:0]  code_q, code_d;
  logic                   down_q, down_d;
  logic [ToW-1:0]         to_cnt_q, to_cnt_d;
  logic [DWELL_WIDTH-1:0] dw_cnt_q, dw_cnt_d;
  logic [DATA_WIDTH-1:0]  points_q, points_d;
  logic                   done_q, done_d, timeout_q, timeout_d;
  logic [2:0]             sync_q;
  logic [DATA_WIDTH-1:0]  data_out_q, rd_data;
  logic                   start_wr, abort_wr, start_accept, done_edge;
  logic [CODE_WIDTH:0]    sum, diff;
  logic                   up_end, dn_end;

  assign start_wr     = we && (addr == AddrCtrl) && data_in[0];
  assign abort_wr     = we && (addr == AddrCtrl) && data_in[1];
  assign start_accept = start_wr && !abort_wr && (state_q == StIdle);
  assign done_edge    = sync_q[1] & ~sync_q[2];

`ifdef SCAN_BIDIR_EN
  logic bidir_q;
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      bidir_q <= 1'b0;
    end else if (we && addr == AddrCtrl) begin
      bidir_q <= data_in[3];
    end
  end
  assign bidir_en = bidir_q;
`else
  assign bidir_en = 1'b0;
`endif

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      cont_q  <= 1'b0;
      start_q <= '0;
      stop_q  <= '1;
      step_q  <= 8'h01;
      dwell_q <= DWELL_WIDTH'('h03E8);
    end else if (we) begin
      unique case (addr)
        AddrCtrl:    cont_q                 <= data_in[2];
        AddrStartLo: start_q[7:0]           <= data_in[7:0];
        AddrStartHi: start_q[CODE_WIDTH-1:8] <= data_in[HiW-1:0];
        AddrStopLo:  stop_q[7:0]            <= data_in[7:0];
        AddrStopHi:  stop_q[CODE_WIDTH-1:8]  <= data_in[HiW-1:0];
        AddrStep:    step_q                 <= data_in[7:0];
        AddrDwellLo: dwell_q[7:0]           <= data_in[7:0];
        AddrDwellHi: dwell_q[15:8]          <= data_in[7:0];
        default: ;
      endcase
    end
  end

  // Running scan works from a snapshot so bus writes cannot disturb it; zero step/dwell run as 1.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      sh_start_q <= '0;
      sh_stop_q  <= '1;
      sh_step_q  <= 8'h01;
      sh_dwell_q <= DWELL_WIDTH'(1);
    end else if (start_accept) begin
      sh_start_q <= start_q;
      sh_stop_q  <= stop_q;
      sh_step_q  <= (step_q == 8'h00) ? 8'h01 : step_q;
      sh_dwell_q <= (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
    end
  end

  assign sum    = {1'b0, code_q} + (CODE_WIDTH + 1)'(sh_step_q);
  assign diff   = {1'b0, code_q} - (CODE_WIDTH + 1)'(sh_step_q);
  assign up_end = sum[CODE_WIDTH] || (sum[CODE_WIDTH-1:0] > sh_stop_q);
  assign dn_end = diff[CODE_WIDTH] || (diff[CODE_WIDTH-1:0] < sh_start_q);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    down_d    = down_q;
    to_cnt_d  = to_cnt_q;
    dw_cnt_d  = dw_cnt_q;
    points_d  = points_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (start_accept) begin
          code_d    = start_q;
          down_d    = 1'b0;
          points_d  = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        to_cnt_d = '0;
        state_d  = StWaitDac;
      end
      StWaitDac: begin
        if (done_edge) begin
          dw_cnt_d = '0;
          state_d  = StDwell;
        end else if (to_cnt_q == ToMax) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StDwell: begin
        if (dw_cnt_q == sh_dwell_q - DWELL_WIDTH'(1)) begin
          points_d = points_q + DATA_WIDTH'(1);
          state_d  = StNext;
        end else begin
          dw_cnt_d = dw_cnt_q + DWELL_WIDTH'(1);
        end
      end
      StNext: begin
        if (!down_q && !up_end) begin
          code_d  = sum[CODE_WIDTH-1:0];
          state_d = StLoad;
        end else if ((down_q || bidir_en) && !dn_end) begin
          // Turning point steps straight down so the top code is not repeated.
          code_d  = diff[CODE_WIDTH-1:0];
          down_d  = 1'b1;
          state_d = StLoad;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d = 1'b1;
        if (cont_q) begin
          code_d  = sh_start_q;
          down_d  = 1'b0;
          state_d = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort_wr) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q   <= StIdle;
      code_q    <= '0;
      down_q    <= 1'b0;
      to_cnt_q  <= '0;
      dw_cnt_q  <= '0;
      points_q  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      down_q    <= down_d;
      to_cnt_q  <= to_cnt_d;
      dw_cnt_q  <= dw_cnt_d;
      points_q  <= points_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      sync_q    <= {sync_q[1:0], dac_done};
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (addr)
      AddrCtrl:    rd_data = DATA_WIDTH'({bidir_en, cont_q, 2'b00});
      AddrStartLo: rd_data = DATA_WIDTH'(start_q[7:0]);
      AddrStartHi: rd_data = DATA_WIDTH'(start_q[CODE_WIDTH-1:8]);
      AddrStopLo:  rd_data = DATA_WIDTH'(stop_q[7:0]);
      AddrStopHi:  rd_data = DATA_WIDTH'(stop_q[CODE_WIDTH-1:8]);
      AddrStep:    rd_data = DATA_WIDTH'(step_q);
      AddrDwellLo: rd_data = DATA_WIDTH'(dwell_q[7:0]);
      AddrDwellHi: rd_data = DATA_WIDTH'(dwell_q[15:8]);
      AddrStatus:  rd_data = DATA_WIDTH'({timeout_q, done_q, busy});
      AddrPoints:  rd_data = points_q;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= rd_data;
    end
  end

  assign data_out       = data_out_q;
  assign dac_code       = code_q;
  assign dac_start_step = (state_q == StLoad) || (state_q == StWaitDac);
  assign count_gate     = (state_q == StDwell);
  assign busy           = (state_q != StIdle);
  assign scan_done      = (state_q == StDone);

endmodule
